// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program-memory instruction fetch unit feeding a CPU instruction port
//
// Purpose:
//   Holds a small program memory that is written while the unit is not
//   running, then issues a run of up to 2^PC_BITS words, one per unstalled
//   cycle, on a registered instruction/instr_valid pair.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   load_en      program-memory write strobe (honoured in IDLE/DONE only)
//   load_addr    program-memory write address
//   load_data    program-memory write data
//   start        launch one run (honoured in IDLE/DONE only)
//   prog_len     words to issue, sampled with an accepted start
//   stall        downstream cannot take a word this cycle
//   instruction  registered instruction word (NOP_INSTR when not valid)
//   instr_valid  instruction carries a real program word
//   pc           address of the next word to fetch
//   busy         run in progress (FETCH)
//   done         run finished (DONE)

module instr_fetch #(
    parameter int                     INSTR_WIDTH = 20,
    parameter int                     PC_BITS     = 5,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   start,
    input  logic [PC_BITS:0]       prog_len,
    input  logic                   stall,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done
);

    localparam int             DEPTH     = 1 << PC_BITS;
    localparam logic [PC_BITS:0] DEPTH_LEN = (PC_BITS+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [PC_BITS-1:0]     pc_q;
    logic [PC_BITS:0]       count_q;
    logic [PC_BITS:0]       len_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   valid_q;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    logic [PC_BITS:0]       len_d;
    logic [PC_BITS:0]       count_d;
    logic                   last_issue;
    logic                   mem_we;
    logic [INSTR_WIDTH-1:0] rd_data;

    always_comb begin
        // Lengths beyond the memory size are clamped so a run never issues a word twice.
        len_d      = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
        count_d    = count_q + 1'b1;
        last_issue = (count_d == len_q);
        // Reset takes priority over a pending write; writes are locked out while fetching.
        mem_we     = load_en && !rst && (state_q != S_FETCH);
        rd_data    = mem[pc_q];
    end

    // Program storage has no reset so a reset does not wipe a loaded program.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            count_q <= '0;
            len_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                    if (start) begin
                        len_q   <= len_d;
                        pc_q    <= '0;
                        count_q <= '0;
                        // A zero-length run completes without ever entering FETCH.
                        state_q <= (len_d != '0) ? S_FETCH : S_DONE;
                    end
                end
                S_FETCH: begin
                    if (stall) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end else begin
                        instr_q <= rd_data;
                        valid_q <= 1'b1;
                        pc_q    <= pc_q + 1'b1;
                        count_q <= count_d;
                        if (last_issue) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == S_FETCH);
    assign done        = (state_q == S_DONE);

endmodule
